// File: rtl/mmio_pkg.sv
// Address map, status-bit layout and address decode for mmio_responder.
package mmio_pkg;

   localparam logic [15:0] RAM_BASE       = 16'h0000;
   localparam logic [15:0] LEDR_ADDR      = 16'h1000;
   localparam logic [15:0] SW_ADDR        = 16'h3000;
   localparam logic [15:0] FIFO_DATA_ADDR = 16'h4000;
   localparam logic [15:0] FIFO_STAT_ADDR = 16'h4001;
   localparam logic [15:0] FIFO_POP_ADDR  = 16'h4002;

   localparam int unsigned STAT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT  = 1;
   localparam int unsigned STAT_COUNT_LSB = 2;

   typedef enum logic [2:0] {
      RegRam,
      RegLedr,
      RegSw,
      RegFifoData,
      RegFifoStat,
      RegFifoPop,
      RegNone
   } region_e;

   // Whole 4 KiB window at the bottom is RAM; everything else is exact-match.
   function automatic region_e decode(input logic [15:0] a);
      region_e r;
      if (a[15:12] == RAM_BASE[15:12]) begin
         r = RegRam;
      end else begin
         case (a)
            LEDR_ADDR:      r = RegLedr;
            SW_ADDR:        r = RegSw;
            FIFO_DATA_ADDR: r = RegFifoData;
            FIFO_STAT_ADDR: r = RegFifoStat;
            FIFO_POP_ADDR:  r = RegFifoPop;
            default:        r = RegNone;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock mailbox FIFO; a pop on the same edge frees room for a push when full.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head  = empty ? '0 : mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped RAM/LED/switch responder with optional mailbox FIFO (MMIO_FIFO_EN).
module mmio_responder
   import mmio_pkg::*;
#(
   parameter int unsigned RAM_AW     = 8,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic [15:0] ADDR,
   input  logic [15:0] DOUT,
   input  logic        W,
   output logic [15:0] DIN,
   input  logic [9:0]  SW,
   output logic [9:0]  LEDR,
   input  logic        ext_rd,
   output logic [15:0] ext_data,
   output logic        ext_valid
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   region_e     region;
   logic [15:0] ram [2**RAM_AW];
   logic [15:0] rd_data;
   logic [15:0] din_q;
   logic [9:0]  ledr_q;

   assign region = decode(ADDR);

   // Gating with Resetn drops a write that coincides with reset assertion.
   always_ff @(posedge Clock) begin
      if (Resetn && W && region == RegRam) ram[ADDR[RAM_AW-1:0]] <= DOUT;
   end

`ifdef MMIO_FIFO_EN
   logic          push, pop, full, empty;
   logic [CW-1:0] count;
   logic [15:0]   head;
   logic [15:0]   stat;

   assign push = W && region == RegFifoData;
   assign pop  = (W && region == RegFifoPop) || ext_rd;

   sync_fifo #(
      .WIDTH(16),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (Clock),
      .rst_n(Resetn),
      .push (push),
      .pop  (pop),
      .wdata(DOUT),
      .head (head),
      .count(count),
      .full (full),
      .empty(empty)
   );

   always_comb begin
      stat                         = '0;
      stat[STAT_COUNT_LSB +: CW]   = count;
      stat[STAT_FULL_BIT]          = full;
      stat[STAT_EMPTY_BIT]         = empty;
   end

   assign ext_data  = head;
   assign ext_valid = !empty;
`else
   logic unused_ext_rd;

   assign unused_ext_rd = ext_rd;
   assign ext_data      = '0;
   assign ext_valid     = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      case (region)
         RegRam:      rd_data = ram[ADDR[RAM_AW-1:0]];
         RegLedr:     rd_data = {6'b0, ledr_q};
         RegSw:       rd_data = {6'b0, SW};
`ifdef MMIO_FIFO_EN
         RegFifoData: rd_data = head;
         RegFifoStat: rd_data = stat;
`endif
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         din_q  <= '0;
         ledr_q <= '0;
      end else begin
         din_q <= rd_data;
         if (W && region == RegLedr) ledr_q <= DOUT[9:0];
      end
   end

   assign DIN  = din_q;
   assign LEDR = ledr_q;

endmodule
